// File: rtl/ym_serial_pkg.sv
// ym_serial_pkg: shared defaults, frame geometry and slot helpers for the YM serial emitter
package ym_serial_pkg;

    localparam int DEF_DCLK_DIV  = 16;
    localparam int DEF_SLOT_BITS = 18;
    localparam int DEF_DATA_W    = 16;
    localparam int FRAME_CYCLES  = 2 * DEF_SLOT_BITS * DEF_DCLK_DIV;
    localparam int PAD_BITS      = DEF_SLOT_BITS - DEF_DATA_W;

    typedef enum logic {
        SLOT_L = 1'b0,
        SLOT_R = 1'b1
    } slot_e;

    function automatic logic [1:0] smp_mask(slot_e s);
        return (s == SLOT_R) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ym_dclk_gen.sv
// ym_dclk_gen: prescaler producing the registered bit clock and bit-tick/bit-start strobes
module ym_dclk_gen
    import ym_serial_pkg::*;
#(
    parameter int DCLK_DIV = DEF_DCLK_DIV
) (
    input  logic clk28,
    input  logic rst,
    input  logic en,
    output logic ym_dclk,
    output logic bit_tick,
    output logic bit_start
);

    localparam int DW = $clog2(DCLK_DIV);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          dclk_q;
    logic          run;

    assign run = en && !rst;

    // next prescaler count: free-running wrap while running, parked at zero otherwise
    always_comb begin
        div_nxt = (!run || div_cnt == DW'(DCLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end

    // count register and bit clock, which is low for the first half of every bit period
    always_ff @(posedge clk28) begin
        if (rst) begin
            div_cnt <= '0;
            dclk_q  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            dclk_q  <= run && (div_nxt >= DW'(DCLK_DIV / 2));
        end
    end

    assign ym_dclk   = run && dclk_q;
    assign bit_tick  = run && (div_cnt == DW'(DCLK_DIV - 1));
    assign bit_start = run && (div_cnt == '0);

endmodule

// File: rtl/ym_serial_tx.sv
// ym_serial_tx: YMF262-style serial stereo sample emitter with a one-pair handshake buffer
module ym_serial_tx
    import ym_serial_pkg::*;
#(
    parameter int DCLK_DIV  = DEF_DCLK_DIV,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] smp_l,
    input  logic [DATA_W-1:0] smp_r,
    input  logic              smp_valid,
    output logic              smp_ready,
    output logic              ym_dclk,
    output logic              ym_data,
    output logic [1:0]        ym_smp,
    output logic              frame_start,
    output logic              underrun
);

    localparam int BW = $clog2(SLOT_BITS);

    logic                 run;
    logic                 bit_tick;
    logic                 bit_start;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_nxt;
    slot_e                slot;
    slot_e                slot_nxt;
    logic                 last_bit;
    logic                 load;
    logic                 accept;
    logic                 buf_full;
    logic [DATA_W-1:0]    buf_l;
    logic [DATA_W-1:0]    buf_r;
    logic [DATA_W-1:0]    cur_l;
    logic [DATA_W-1:0]    cur_r;
    logic [SLOT_BITS-1:0] word;
    logic                 data_q;
    logic [1:0]           smp_q;

    ym_dclk_gen #(
        .DCLK_DIV (DCLK_DIV)
    ) u_dclk (
        .clk28     (clk28),
        .rst       (rst),
        .en        (en),
        .ym_dclk   (ym_dclk),
        .bit_tick  (bit_tick),
        .bit_start (bit_start)
    );

    assign run         = en && !rst;
    assign last_bit    = bit_cnt == BW'(SLOT_BITS - 1);
    assign load        = bit_start && bit_cnt == '0 && slot == SLOT_L;
    assign smp_ready   = !buf_full && !rst;
    assign accept      = smp_valid && smp_ready;
    assign frame_start = load;
    assign underrun    = load && !buf_full;
    assign ym_data     = run && data_q;
    assign ym_smp      = run ? smp_q : 2'b00;

    // bit/slot position for the next cycle; zero-extending the sample puts the pad bits first,
    // so shifting by the bit position leaves the outgoing bit in the MSB
    always_comb begin
        bit_nxt  = !run ? '0 : bit_tick ? (last_bit ? '0 : bit_cnt + 1'b1) : bit_cnt;
        slot_nxt = !run ? SLOT_L : (bit_tick && last_bit) ? slot_e'(~slot) : slot;
        word     = SLOT_BITS'(slot_nxt == SLOT_R ? cur_r : cur_l) << bit_nxt;
    end

    // position counters, registered serial outputs, handshake buffer and frame registers
    always_ff @(posedge clk28) begin
        if (rst) begin
            bit_cnt  <= '0;
            slot     <= SLOT_L;
            data_q   <= 1'b0;
            smp_q    <= 2'b00;
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            cur_l    <= '0;
            cur_r    <= '0;
        end else begin
            bit_cnt  <= bit_nxt;
            slot     <= slot_nxt;
            data_q   <= run && word[SLOT_BITS-1];
            smp_q    <= (run && bit_nxt == BW'(SLOT_BITS - 1)) ? smp_mask(slot_nxt) : 2'b00;
            buf_full <= accept || (buf_full && !load);
            if (accept) begin
                buf_l <= smp_l;
                buf_r <= smp_r;
            end
            if (load && buf_full) begin
                cur_l <= buf_l;
                cur_r <= buf_r;
            end
        end
    end

endmodule

// File: tb/tb_ym_serial_tx.sv
// tb_ym_serial_tx: frame-position reference model plus directed and random stimulus for ym_serial_tx
module tb_ym_serial_tx;

    localparam int DIV   = 16;
    localparam int SB    = 18;
    localparam int PAD   = 2;
    localparam int FRAME = 2 * SB * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] smp_l;
    logic [15:0] smp_r;
    logic        smp_valid;
    logic        smp_ready;
    logic        ym_dclk;
    logic        ym_data;
    logic [1:0]  ym_smp;
    logic        frame_start;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    ym_serial_tx dut (
        .clk28       (clk),
        .rst         (rst),
        .en          (en),
        .smp_l       (smp_l),
        .smp_r       (smp_r),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .ym_dclk     (ym_dclk),
        .ym_data     (ym_data),
        .ym_smp      (ym_smp),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // reference model: outputs follow from the position inside the frame since the stream started
    int          m_t = 0;
    int          m_p, m_b, m_s;
    logic        m_run, m_acc;
    logic        m_full = 1'b0;
    logic [15:0] mb_l = '0, mb_r = '0, mc_l = '0, mc_r = '0, m_w;
    logic [6:0]  m_exp, m_got;

    always @(negedge clk) begin
        m_run = en && !rst;
        m_p   = m_t % FRAME;
        m_b   = (m_p % (SB * DIV)) / DIV;
        m_s   = m_p / (SB * DIV);
        m_w   = (m_s == 1 ? mc_r : mc_l) << (m_b - PAD);
        m_exp = '0;
        m_exp[6] = !rst && !m_full;
        if (m_run) begin
            m_exp[5]   = (m_p % DIV) >= DIV / 2;
            m_exp[4]   = (m_b >= PAD) && m_w[15];
            m_exp[3:2] = (m_b == SB - 1) ? (m_s == 1 ? 2'b10 : 2'b01) : 2'b00;
            m_exp[1]   = m_p == 0;
            m_exp[0]   = m_p == 0 && !m_full;
        end
        m_got = {smp_ready, ym_dclk, ym_data, ym_smp, frame_start, underrun};
        checks++;
        if (m_got !== m_exp) begin
            failures++;
            $display("FAIL model_cycle t=%0t got=%b exp=%b (ready,dclk,data,smp[1:0],fs,ur)", $time, m_got, m_exp);
        end
        m_acc = smp_valid && m_exp[6];
        if (rst) begin
            m_full = 1'b0;
            mc_l   = '0;
            mc_r   = '0;
            m_t    = 0;
        end else begin
            if (m_run && m_p == 0 && m_full) begin
                mc_l   = mb_l;
                mc_r   = mb_r;
                m_full = 1'b0;
            end
            if (m_acc) begin
                mb_l   = smp_l;
                mb_r   = smp_r;
                m_full = 1'b1;
            end
            m_t = m_run ? m_t + 1 : 0;
        end
    end

    // stream decoder: reassembles 36-bit frames at ym_dclk rising edges and matches accepted pairs in order
    logic        dec_on = 1'b0;
    logic        d_prev = 1'b0;
    logic [35:0] d_sh = '0;
    logic [35:0] d_ef;
    logic [31:0] d_pair;
    int          d_n = 0;
    int          d_frames = 0;
    logic [31:0] pq[$];

    always @(negedge clk) begin
        if (!dec_on || !en) begin
            d_n  = 0;
            d_sh = '0;
        end else if (ym_dclk && !d_prev) begin
            d_sh = {d_sh[34:0], ym_data};
            d_n++;
            if (d_n == 36) begin
                d_n = 0;
                checks++;
                if (pq.size() == 0) begin
                    failures++;
                    $display("FAIL decode_frame got=%h exp=<no accepted pair>", d_sh);
                end else begin
                    d_pair = pq.pop_front();
                    d_ef   = {2'b00, d_pair[31:16], 2'b00, d_pair[15:0]};
                    if (d_sh !== d_ef) begin
                        failures++;
                        $display("FAIL decode_frame got=%h exp=%h", d_sh, d_ef);
                    end
                    d_frames++;
                end
            end
        end
        d_prev = ym_dclk;
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic decode_frame(output logic [35:0] bits, output logic fs0, output logic ur0,
                                output int s0f, output int s0c, output int s1f, output int s1c);
        logic pd;
        pd   = 1'b0;
        bits = '0;
        s0f  = -1;
        s1f  = -1;
        s0c  = 0;
        s1c  = 0;
        fs0  = 1'b0;
        ur0  = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == 0) begin
                fs0 = frame_start;
                ur0 = underrun;
            end
            if (ym_dclk && !pd) bits = {bits[34:0], ym_data};
            pd = ym_dclk;
            if (ym_smp[0]) begin
                if (s0f < 0) s0f = k;
                s0c++;
            end
            if (ym_smp[1]) begin
                if (s1f < 0) s1f = k;
                s1c++;
            end
        end
    endtask

    logic [35:0] fb;
    logic        fs0, ur0, found, leak, nz, acc;
    int          s0f, s0c, s1f, s1c;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        smp_valid = 1'b0;
        smp_l     = '0;
        smp_r     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("rst_ready", smp_ready, 0);
        lit("rst_outputs", {ym_dclk, ym_data, ym_smp, frame_start, underrun}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        lit("ready_after_rst", smp_ready, 1);

        // single frame, then an underrun repeat
        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_l     = 16'hA55A;
        smp_r     = 16'h0001;
        @(posedge clk); #1;
        smp_valid = 1'b0;
        en        = 1'b1;
        decode_frame(fb, fs0, ur0, s0f, s0c, s1f, s1c);
        lit("f1_bits", fb, {18'h0A55A, 18'h00001});
        lit("f1_frame_start", fs0, 1);
        lit("f1_underrun", ur0, 0);
        lit("f1_smp0_first", s0f, 272);
        lit("f1_smp0_len", s0c, 16);
        lit("f1_smp1_first", s1f, 560);
        lit("f1_smp1_len", s1c, 16);
        decode_frame(fb, fs0, ur0, s0f, s0c, s1f, s1c);
        lit("f2_bits", fb, {18'h0A55A, 18'h00001});
        lit("f2_frame_start", fs0, 1);
        lit("f2_underrun", ur0, 1);

        // back-pressure: P1 offered in a load cycle, P2 waits until the following load
        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_l     = 16'h1234;
        smp_r     = 16'hFEDC;
        @(posedge clk); #1;
        smp_l = 16'h8001;
        smp_r = 16'h7FFE;
        @(negedge clk);
        lit("bp_ready_low", smp_ready, 0);
        found = 1'b0;
        leak  = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
            else if (smp_ready) leak = 1'b1;
        end
        lit("bp_load_seen", found, 1);
        lit("bp_no_early_ready", leak, 0);
        lit("bp_ready_at_load", smp_ready, 0);
        lit("bp_load_underrun", underrun, 0);
        @(posedge clk); #1;
        @(negedge clk);
        lit("bp_p2_ready", smp_ready, 1);
        @(posedge clk); #1;
        smp_valid = 1'b0;
        decode_frame(fb, fs0, ur0, s0f, s0c, s1f, s1c);
        lit("bp_p1_bits", fb, {18'h01234, 18'h0FEDC});
        decode_frame(fb, fs0, ur0, s0f, s0c, s1f, s1c);
        lit("bp_p2_bits", fb, {18'h08001, 18'h07FFE});

        // en dropped mid-frame for 10 cycles, then restarted from bit 0 with held data
        repeat (99) @(posedge clk);
        #1;
        en = 1'b0;
        nz = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({ym_dclk, ym_data, ym_smp, frame_start, underrun} != 0) nz = 1'b1;
            @(posedge clk); #1;
        end
        lit("en_low_outputs", nz, 0);
        en = 1'b1;
        decode_frame(fb, fs0, ur0, s0f, s0c, s1f, s1c);
        lit("restart_frame_start", fs0, 1);
        lit("restart_underrun", ur0, 1);
        lit("restart_smp0_first", s0f, 272);
        lit("restart_bits", fb, {18'h08001, 18'h07FFE});

        // producer that keeps up: every accepted random pair must come out in order
        @(posedge clk); #1;
        en  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        smp_l     = 16'($urandom);
        smp_r     = 16'($urandom);
        smp_valid = 1'b1;
        dec_on    = 1'b1;
        for (int i = 0; i < 7 * FRAME + 2; i++) begin
            @(negedge clk);
            acc = smp_valid && smp_ready;
            if (acc) pq.push_back({smp_l, smp_r});
            @(posedge clk); #1;
            if (acc) begin
                smp_l = 16'($urandom);
                smp_r = 16'($urandom);
            end
            if (i == 0) en = 1'b1;
        end
        en        = 1'b0;
        smp_valid = 1'b0;
        dec_on    = 1'b0;
        lit("decoded_frames", d_frames, 7);

        // random traffic with en gaps and a mid-frame reset, checked by the reference model
        for (int i = 0; i < 9000; i++) begin
            @(posedge clk); #1;
            smp_valid = ($urandom_range(0, 2) == 0);
            smp_l     = 16'($urandom);
            smp_r     = 16'($urandom);
            en        = !((i % 2000) >= 1500 && (i % 2000) < 1530) && ($urandom_range(0, 799) != 0);
            rst       = (i == 4321) || (i == 4322);
        end
        @(posedge clk); #1;
        en        = 1'b0;
        smp_valid = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
